// File: rtl/instruction_parse.sv
// LEGv8 instruction field extractor: combinational decode of fields, format and
// immediate, plus a one-deep registered copy qualified by instr_valid.
module instruction_parse #(
    parameter int unsigned INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic                 instr_valid,
    output logic [10:0]          opcode,
    output logic [8:0]           address,
    output logic [4:0]           rm_num,
    output logic [4:0]           rn_num,
    output logic [4:0]           rd_num,
    output logic [2:0]           fmt,
    output logic [63:0]          imm,
    output logic [5:0]           shamt,
    output logic                 q_valid,
    output logic [2:0]           q_fmt,
    output logic [10:0]          q_opcode,
    output logic [4:0]           q_rm_num,
    output logic [4:0]           q_rn_num,
    output logic [4:0]           q_rd_num,
    output logic [63:0]          q_imm
);

    localparam int unsigned OP_W  = 11;
    localparam int unsigned IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_UNKNOWN = 3'd0,
        FMT_R       = 3'd1,
        FMT_I       = 3'd2,
        FMT_D       = 3'd3,
        FMT_B       = 3'd4,
        FMT_CB      = 3'd5,
        FMT_IW      = 3'd6
    } fmt_e;

    logic [OP_W-1:0]  w_opcode;
    fmt_e             w_fmt;
    logic [IMM_W-1:0] w_imm;

    assign w_opcode = instruction[31:21];

    // Format decode; checked in R, D, I, IW, CB, B order
    always_comb begin
        w_fmt = FMT_UNKNOWN;
        if (w_opcode inside {11'd1112, 11'd1624, 11'd1104, 11'd1360,
                             11'd1616, 11'd1691, 11'd1690, 11'd1712})
            w_fmt = FMT_R;
        else if (w_opcode inside {11'd1986, 11'd1984})
            w_fmt = FMT_D;
        else if (w_opcode[10:1] inside {10'd580, 10'd836, 10'd584, 10'd712})
            w_fmt = FMT_I;
        else if (w_opcode[10:2] inside {9'd421, 9'd485})
            w_fmt = FMT_IW;
        else if (w_opcode[10:3] inside {8'd180, 8'd181, 8'd84})
            w_fmt = FMT_CB;
        else if (w_opcode[10:5] == 6'b000101)
            w_fmt = FMT_B;
    end

    // Immediate extension for the decoded format
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = {52'd0, instruction[21:10]};
            FMT_D:   w_imm = {{55{instruction[20]}}, instruction[20:12]};
            FMT_B:   w_imm = {{38{instruction[25]}}, instruction[25:0]};
            FMT_CB:  w_imm = {{45{instruction[23]}}, instruction[23:5]};
            FMT_IW:  w_imm = {48'd0, instruction[20:5]};
            default: w_imm = '0;
        endcase
    end

    assign opcode  = w_opcode;
    assign address = instruction[20:12];
    assign rm_num  = instruction[20:16];
    assign rn_num  = instruction[9:5];
    assign rd_num  = instruction[4:0];
    assign shamt   = instruction[15:10];
    assign fmt     = w_fmt;
    assign imm     = w_imm;

    logic             r_valid;
    logic [2:0]       r_fmt;
    logic [OP_W-1:0]  r_opcode;
    logic [4:0]       r_rm_num;
    logic [4:0]       r_rn_num;
    logic [4:0]       r_rd_num;
    logic [IMM_W-1:0] r_imm;

    // Capture stage: data only updates on a valid word, valid tracks instr_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_fmt    <= '0;
            r_opcode <= '0;
            r_rm_num <= '0;
            r_rn_num <= '0;
            r_rd_num <= '0;
            r_imm    <= '0;
        end else begin
            r_valid <= instr_valid;
            if (instr_valid) begin
                r_fmt    <= w_fmt;
                r_opcode <= w_opcode;
                r_rm_num <= instruction[20:16];
                r_rn_num <= instruction[9:5];
                r_rd_num <= instruction[4:0];
                r_imm    <= w_imm;
            end
        end
    end

    assign q_valid  = r_valid;
    assign q_fmt    = r_fmt;
    assign q_opcode = r_opcode;
    assign q_rm_num = r_rm_num;
    assign q_rn_num = r_rn_num;
    assign q_rd_num = r_rd_num;
    assign q_imm    = r_imm;

endmodule

// File: tb/tb_instruction_parse.sv
// Self-checking bench for instruction_parse: directed LEGv8 words plus random
// words compared against an arithmetic reference model.
module tb_instruction_parse;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [10:0] opcode;
    logic [8:0]  address;
    logic [4:0]  rm_num, rn_num, rd_num;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [5:0]  shamt;
    logic        q_valid;
    logic [2:0]  q_fmt;
    logic [10:0] q_opcode;
    logic [4:0]  q_rm_num, q_rn_num, q_rd_num;
    logic [63:0] q_imm;

    int n_checks = 0;
    int n_errors = 0;

    instruction_parse #(.INSTR_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .opcode(opcode), .address(address), .rm_num(rm_num), .rn_num(rn_num),
        .rd_num(rd_num), .fmt(fmt), .imm(imm), .shamt(shamt),
        .q_valid(q_valid), .q_fmt(q_fmt), .q_opcode(q_opcode), .q_rm_num(q_rm_num),
        .q_rn_num(q_rn_num), .q_rd_num(q_rd_num), .q_imm(q_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the word value
    function automatic longint unsigned fld(input logic [31:0] w, input int lo, input int n);
        longint unsigned v = 64'(w);
        return (v >> lo) % (64'd1 << n);
    endfunction

    function automatic logic [63:0] sext(input longint unsigned v, input int bits);
        longint s = longint'(v);
        if (v >= (64'd1 << (bits - 1))) s = s - (longint'(1) << bits);
        return 64'(s);
    endfunction

    function automatic int m_fmt(input logic [31:0] w);
        int op = int'(fld(w, 21, 11));
        if (op inside {1112, 1624, 1104, 1360, 1616, 1691, 1690, 1712}) return 1;
        if (op == 1986 || op == 1984) return 3;
        if ((op / 2) inside {580, 836, 584, 712}) return 2;
        if ((op / 4) inside {421, 485}) return 6;
        if ((op / 8) inside {180, 181, 84}) return 5;
        if ((op / 32) == 5) return 4;
        return 0;
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] w);
        case (m_fmt(w))
            2: return 64'(fld(w, 10, 12));
            3: return sext(fld(w, 12, 9), 9);
            4: return sext(fld(w, 0, 26), 26);
            5: return sext(fld(w, 5, 19), 19);
            6: return 64'(fld(w, 5, 16));
            default: return 64'd0;
        endcase
    endfunction

    // Word generator biased towards each format's opcode space
    function automatic logic [31:0] gen_word();
        int unsigned r_ops[8] = '{1112, 1624, 1104, 1360, 1616, 1691, 1690, 1712};
        int unsigned i_ops[4] = '{580, 836, 584, 712};
        int unsigned cb_ops[3] = '{180, 181, 84};
        int unsigned w;
        case ($urandom_range(0, 6))
            0: w = r_ops[$urandom_range(0, 7)] * (1 << 21) + $urandom_range(0, (1 << 21) - 1);
            1: w = i_ops[$urandom_range(0, 3)] * (1 << 22) + $urandom_range(0, (1 << 22) - 1);
            2: w = (($urandom_range(0, 1) == 1) ? 1986 : 1984) * (1 << 21) + $urandom_range(0, (1 << 21) - 1);
            3: w = 5 * (1 << 26) + $urandom_range(0, (1 << 26) - 1);
            4: w = cb_ops[$urandom_range(0, 2)] * (1 << 24) + $urandom_range(0, (1 << 24) - 1);
            5: w = (($urandom_range(0, 1) == 1) ? 421 : 485) * (1 << 23) + $urandom_range(0, (1 << 23) - 1);
            default: w = $urandom;
        endcase
        return 32'(w);
    endfunction

    task automatic check_comb(input logic [31:0] w);
        instruction = w;
        #2;
        check("opcode",  64'(opcode),  64'(fld(w, 21, 11)));
        check("address", 64'(address), 64'(fld(w, 12, 9)));
        check("rm_num",  64'(rm_num),  64'(fld(w, 16, 5)));
        check("rn_num",  64'(rn_num),  64'(fld(w, 5, 5)));
        check("rd_num",  64'(rd_num),  64'(fld(w, 0, 5)));
        check("shamt",   64'(shamt),   64'(fld(w, 10, 6)));
        check("fmt",     64'(fmt),     64'(m_fmt(w)));
        check("imm",     imm,          m_imm(w));
    endtask

    logic        e_valid;
    logic [31:0] e_word;

    task automatic check_q();
        check("q_valid", 64'(q_valid), 64'(e_valid));
        check("q_fmt",    64'(q_fmt),    64'(m_fmt(e_word)));
        check("q_opcode", 64'(q_opcode), 64'(fld(e_word, 21, 11)));
        check("q_rm_num", 64'(q_rm_num), 64'(fld(e_word, 16, 5)));
        check("q_rn_num", 64'(q_rn_num), 64'(fld(e_word, 5, 5)));
        check("q_rd_num", 64'(q_rd_num), 64'(fld(e_word, 0, 5)));
        check("q_imm",    q_imm,         m_imm(e_word));
    endtask

    task automatic check_q_zero(input string tag);
        check({tag, "_valid"}, 64'(q_valid), 64'd0);
        check({tag, "_fmt"},   64'(q_fmt),   64'd0);
        check({tag, "_op"},    64'(q_opcode), 64'd0);
        check({tag, "_rm"},    64'(q_rm_num), 64'd0);
        check({tag, "_rn"},    64'(q_rn_num), 64'd0);
        check({tag, "_rd"},    64'(q_rd_num), 64'd0);
        check({tag, "_imm"},   q_imm,        64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = 32'h0;
        instr_valid = 1'b0;
        e_valid = 1'b0;
        e_word = 32'h0;
        #3;
        check_q_zero("rst");
        // Combinational path unaffected by reset
        instruction = 32'h8B0902AA;
        #2;
        check("rst_comb_fmt", 64'(fmt), 64'd1);
        check("rst_comb_op", 64'(opcode), 64'd1112);

        // Directed words with hand-derived expectations
        check_comb(32'hF84F02C9);
        check("ldur_rn", 64'(rn_num), 64'd22);
        check("ldur_rd", 64'(rd_num), 64'd9);
        check("ldur_addr", 64'(address), 64'd240);
        check("ldur_op", 64'(opcode), 64'd1986);
        check("ldur_fmt", 64'(fmt), 64'd3);
        check("ldur_imm", imm, 64'd240);
        check_comb(32'h8B0902AA);
        check("add_rm", 64'(rm_num), 64'd9);
        check("add_rn", 64'(rn_num), 64'd21);
        check("add_rd", 64'(rd_num), 64'd10);
        check("add_fmt", 64'(fmt), 64'd1);
        check("add_imm", imm, 64'd0);
        check_comb(32'hF80402EA);
        check("stur_rn", 64'(rn_num), 64'd23);
        check("stur_rd", 64'(rd_num), 64'd10);
        check("stur_addr", 64'(address), 64'd64);
        check("stur_op", 64'(opcode), 64'd1984);
        check("stur_fmt", 64'(fmt), 64'd3);
        check_comb(32'h17FFFFFF);
        check("b_fmt", 64'(fmt), 64'd4);
        check("b_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_comb(32'hF85FF000);
        check("ldur_neg_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_comb(32'h00000000);
        check("unk_fmt", 64'(fmt), 64'd0);
        check("unk_imm", imm, 64'd0);
        check("unk_rd", 64'(rd_num), 64'd0);

        // Registered stage: first capture, hold, async reset, reset wins
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        instruction = 32'h8B0902AA;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        check("reg_valid", 64'(q_valid), 64'd1);
        check("reg_op", 64'(q_opcode), 64'd1112);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = 32'hF84F02C9;
        @(posedge clk);
        #1;
        check("hold_valid", 64'(q_valid), 64'd0);
        check("hold_op", 64'(q_opcode), 64'd1112);
        check("hold_rd", 64'(q_rd_num), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_q_zero("midrst");
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        check_q_zero("rstwin");
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            logic v;
            @(negedge clk);
            w = gen_word();
            v = ($urandom_range(0, 9) < 7);
            instr_valid = v;
            check_comb(w);
            @(posedge clk);
            e_valid = v;
            if (v) e_word = w;
            #1;
            check_q();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_parse.md
INSTRUCTION_PARSE -- requirements
Module: instruction_parse

Interface
REQ-001 Parameter: INSTR_LEN, default 32, instruction word width; only 32 is supported.
REQ-002 Clocking: the block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the registered stage.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instruction  input  32  LEGv8 machine-code word.
REQ-006 instr_valid  input  1  qualifies instruction for capture into the registered stage.
REQ-007 opcode  output  11  instruction[31:21], combinational.
REQ-008 address  output  9  D-type offset instruction[20:12], combinational.
REQ-009 rm_num  output  5  instruction[20:16], combinational.
REQ-010 rn_num  output  5  instruction[9:5], combinational.
REQ-011 rd_num  output  5  instruction[4:0], combinational; this field also carries Rt for D/CB types.
REQ-012 fmt  output  3  format code, combinational: 0 UNKNOWN, 1 R, 2 I, 3 D, 4 B, 5 CB, 6 IW.
REQ-013 imm  output  64  sign/zero-extended immediate of the decoded format, combinational.
REQ-014 shamt  output  6  instruction[15:10], combinational.
REQ-015 q_valid  output  1  registered-stage valid flag.
REQ-016 q_fmt, q_opcode, q_rm_num, q_rn_num, q_rd_num, q_imm  outputs  3/11/5/5/5/64  registered copies of the combinational outputs.

Function
REQ-017 The combinational outputs SHALL depend only on instruction, with no clock dependency, and SHALL settle within 2 ns of an instruction change.
REQ-018 The combinational field outputs SHALL be extracted for every word regardless of format; irrelevant fields still carry the raw bits.
REQ-019 fmt decode SHALL follow opcode bits.
- R: 11-bit opcode in {1112 ADD, 1624 SUB, 1104 AND, 1360 ORR, 1616 EOR, 1691 LSL, 1690 LSR, 1712 BR}.
- I: opcode[10:1] in {580 ADDI, 836 SUBI, 584 ANDI, 712 ORRI}.
- D: opcode in {1986 LDUR, 1984 STUR}.
- B: opcode[10:5] = 6'b000101.
- CB: opcode[10:3] in {180 CBZ, 181 CBNZ, 84 B.cond}.
- IW: opcode[10:2] in {421 MOVZ, 485 MOVK}.
- Otherwise: UNKNOWN.
REQ-020 imm by fmt.
- I: zero-extended instruction[21:10].
- D: sign-extended instruction[20:12].
- B: sign-extended instruction[25:0].
- CB: sign-extended instruction[23:5].
- IW: zero-extended instruction[20:5].
- R/UNKNOWN: 0.
REQ-021 Decode priority SHALL be R, D, I, IW, CB, B; the specified sets do not overlap, so priority only fixes implementation order.
REQ-022 Registered stage timing.
- On a rising clk edge with instr_valid=1: all q_* outputs capture the current combinational values, and q_valid becomes 1.
- On a rising clk edge with instr_valid=0: q_valid becomes 0, and the q_* data outputs hold their values.
- Latency is 1 cycle.
REQ-023 The registered stage SHALL have no backpressure; every valid word is captured.

Reset
REQ-024 While rst_n=0, q_valid and all q_* outputs SHALL be 0 immediately, with no clock required.
REQ-025 Reset SHALL NOT affect the combinational outputs.
REQ-026 The first capture SHALL occur on the first rising clk edge after rst_n deasserts with instr_valid=1.
REQ-027 If reset is asserted in the same cycle as a capture, reset SHALL win.

Verification
REQ-028 LDUR X9,[X22,#240] = 0xF84F02C9 -> rn=22, rd=9, address=240, opcode=1986, fmt=D, imm=240 (checked 2 ns after apply).
REQ-029 ADD X10,X21,X9 = 0x8B0902AA -> rm=9, rn=21, rd=10, opcode=1112, fmt=R, imm=0.
REQ-030 STUR X10,[X23,#64] = 0xF80402EA -> rn=23, rd=10, address=64, opcode=1984, fmt=D.
REQ-031 Sign extension: B with instruction[25:0] all ones = 0x17FFFFFF -> fmt=B, imm=64'hFFFF_FFFF_FFFF_FFFF; LDUR with address=9'h1FF -> imm=-1.
REQ-032 Registered stage: apply 0x8B0902AA with instr_valid=1 -> after one edge q_valid=1, q_opcode=1112; then instr_valid=0 -> q_valid=0 and q_opcode holds 1112; assert rst_n=0 mid-cycle -> all q_* outputs read 0 with no edge.
REQ-033 Unknown format: 0x00000000 -> fmt=UNKNOWN, imm=0, all fields 0.
